// File: rtl/sdm_rx_drain.sv
// Drains the sigma-delta receiver: waits for decoded samples to settle, captures and pops them,
// decimates blocks of 2^LOG2N samples into sum/average, and tracks clipping and handshake timeouts.
module sdm_rx_drain #(
  parameter int unsigned LOG2N  = 2,
  parameter int unsigned SETTLE = 3,
  parameter int unsigned TMO    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             full,
  input  logic [3:0]       rdata,
  output logic             pop,
  output logic [3+LOG2N:0] sum_out,
  output logic [3:0]       avg_out,
  output logic             out_valid,
  output logic [7:0]       clip_cnt,
  output logic             err_timeout,
  input  logic             clr_err
);

  localparam int unsigned AW = 4 + LOG2N;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_POP,
    S_WAITLOW
  } state_t;

  state_t                 state, state_nxt;
  logic [3:0]             settle_tmr, settle_tmr_nxt;
  logic [7:0]             tmo_tmr, tmo_tmr_nxt;
  logic signed [AW-1:0]   acc, acc_nxt;
  logic [LOG2N-1:0]       cnt, cnt_nxt;
  logic signed [AW-1:0]   samp_ext, acc_sum;
  logic                   pop_nxt, tmo_fire, clip_hit, blk_done;

  assign samp_ext = {{LOG2N{rdata[3]}}, rdata};
  assign acc_sum  = acc + samp_ext;

  always_comb begin
    state_nxt      = state;
    settle_tmr_nxt = settle_tmr;
    tmo_tmr_nxt    = tmo_tmr;
    acc_nxt        = acc;
    cnt_nxt        = cnt;
    pop_nxt        = 1'b0;
    tmo_fire       = 1'b0;
    clip_hit       = 1'b0;
    blk_done       = 1'b0;
    case (state)
      S_IDLE: begin
        // A disabled drain discards any partial block.
        if (!enable) begin
          acc_nxt = '0;
          cnt_nxt = '0;
        end
        if (enable && full) begin
          state_nxt      = S_SETTLE;
          settle_tmr_nxt = 4'(SETTLE - 1);
        end
      end
      S_SETTLE: begin
        if (settle_tmr == '0) state_nxt = S_CAPTURE;
        else                  settle_tmr_nxt = settle_tmr - 4'd1;
      end
      S_CAPTURE: begin
        clip_hit = (rdata == 4'b1000) || (rdata == 4'b0111);
        blk_done = &cnt;
        if (blk_done) begin
          acc_nxt = '0;
          cnt_nxt = '0;
        end else begin
          acc_nxt = acc_sum;
          cnt_nxt = cnt + LOG2N'(1);
        end
        state_nxt = S_POP;
        pop_nxt   = 1'b1;
      end
      S_POP: begin
        state_nxt   = S_WAITLOW;
        tmo_tmr_nxt = '0;
      end
      S_WAITLOW: begin
        if (!full) begin
          state_nxt = S_IDLE;
        end else if (tmo_tmr == 8'(TMO - 1)) begin
          tmo_fire    = 1'b1;
          pop_nxt     = 1'b1;
          tmo_tmr_nxt = '0;
        end else begin
          tmo_tmr_nxt = tmo_tmr + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_tmr  <= '0;
      tmo_tmr     <= '0;
      acc         <= '0;
      cnt         <= '0;
      pop         <= 1'b0;
      sum_out     <= '0;
      avg_out     <= '0;
      out_valid   <= 1'b0;
      clip_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_tmr <= settle_tmr_nxt;
      tmo_tmr    <= tmo_tmr_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      pop        <= pop_nxt;
      out_valid  <= blk_done;
      if (blk_done) begin
        sum_out <= acc_sum;
        avg_out <= 4'(acc_sum >>> LOG2N);
      end
      if (clr_err)                          clip_cnt <= '0;
      else if (clip_hit && clip_cnt != '1)  clip_cnt <= clip_cnt + 8'd1;
      if (clr_err)       err_timeout <= 1'b0;
      else if (tmo_fire) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdm_rx_drain.sv
// Directed bench for sdm_rx_drain (LOG2N=2, SETTLE=3, TMO=64) with hand-computed expectations.
module tb_sdm_rx_drain;

  logic       clk = 1'b0;
  logic       rst, enable, full, clr_err;
  logic [3:0] rdata;
  logic       pop, out_valid, err_timeout;
  logic [5:0] sum_out;
  logic [3:0] avg_out;
  logic [7:0] clip_cnt;

  int total = 0;
  int bad   = 0;
  int nvalid = 0;
  int npop   = 0;
  int vsum   = 0;
  int vavg   = 0;

  sdm_rx_drain #(.LOG2N(2), .SETTLE(3), .TMO(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .full        (full),
    .rdata       (rdata),
    .pop         (pop),
    .sum_out     (sum_out),
    .avg_out     (avg_out),
    .out_valid   (out_valid),
    .clip_cnt    (clip_cnt),
    .err_timeout (err_timeout),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      nvalid++;
      vsum = int'($signed(sum_out));
      vavg = int'($signed(avg_out));
    end
    if (pop) npop++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One receiver frame: raise full, expect pop on the 5th falling edge, then drop full.
  task automatic frame(input logic [3:0] d, input bit clr_cap);
    int n = 0;
    rdata = d;
    full  = 1'b1;
    do begin
      @(negedge clk);
      n++;
      clr_err = clr_cap && (n == 4);
    end while (!pop && n < 20);
    chk("pop_lat", n, 5);
    clr_err = 1'b0;
    full    = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic block_chk(input string tag, input int es, input int ea);
    chk({tag, "_nvalid"}, nvalid, 1);
    chk({tag, "_sum"}, vsum, es);
    chk({tag, "_avg"}, vavg, ea);
    nvalid = 0;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_pop"}, int'(pop), 0);
    chk({tag, "_sum"}, int'($signed(sum_out)), 0);
    chk({tag, "_avg"}, int'($signed(avg_out)), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_clip"}, int'(clip_cnt), 0);
    chk({tag, "_err"}, int'(err_timeout), 0);
  endtask

  initial begin
    int p0, hold_pops;
    logic [3:0] v4 [4];
    rst = 1'b1; enable = 1'b0; full = 1'b0; clr_err = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    zero_chk("reset");
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    nvalid = 0; npop = 0;

    // four +3 frames
    for (int i = 0; i < 4; i++) frame(4'd3, 1'b0);
    block_chk("p3", 12, 3);
    chk("p3_npop", npop, 4);
    chk("p3_clip", int'(clip_cnt), 0);

    // four -8 frames, then clear
    for (int i = 0; i < 4; i++) frame(4'h8, 1'b0);
    block_chk("m8", -32, -8);
    chk("m8_clip", int'(clip_cnt), 4);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_clip", int'(clip_cnt), 0);
    chk("hold_sum", int'($signed(sum_out)), -32);

    // floor average on a negative sum, then near-clip block
    v4 = '{4'd1, 4'hE, 4'd0, 4'd0};
    for (int i = 0; i < 4; i++) frame(v4[i], 1'b0);
    block_chk("floor", -1, -1);
    v4 = '{4'd7, 4'd7, 4'd7, 4'd6};
    for (int i = 0; i < 4; i++) frame(v4[i], 1'b0);
    block_chk("hi", 27, 6);
    chk("hi_clip", int'(clip_cnt), 3);

    // hold full high after pop: timeout every 64 cycles
    rdata = 4'd1;
    full  = 1'b1;
    p0 = 0;
    do begin @(negedge clk); p0++; end while (!pop && p0 < 20);
    chk("tmo_pop_lat", p0, 5);
    hold_pops = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (pop) hold_pops++;
      if (i == 64) chk("tmo_err_early", int'(err_timeout), 0);
      if (i == 65) begin
        chk("tmo_err", int'(err_timeout), 1);
        chk("tmo_repop", int'(pop), 1);
      end
    end
    chk("tmo_pops", hold_pops, 3);
    full = 1'b0;
    p0 = npop;
    repeat (80) @(negedge clk);
    chk("tmo_quiet", npop - p0, 0);
    chk("tmo_sticky", int'(err_timeout), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("tmo_clr", int'(err_timeout), 0);

    // partial block discarded across an enable drop
    nvalid = 0;
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    frame(4'd7, 1'b0);
    frame(4'd7, 1'b0);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) frame(4'd2, 1'b0);
    block_chk("discard", 8, 2);
    chk("discard_clip", int'(clip_cnt), 2);

    // reset during SETTLE
    rdata = 4'd5; full = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; full = 1'b0;
    @(negedge clk);
    zero_chk("rst_settle");
    rst = 1'b0;
    p0 = npop;
    repeat (10) @(negedge clk);
    chk("rst_settle_nopop", npop - p0, 0);

    // reset during POP
    rdata = 4'd7; full = 1'b1;
    p0 = 0;
    do begin @(negedge clk); p0++; end while (!pop && p0 < 20);
    chk("rstpop_lat", p0, 5);
    rst = 1'b1; full = 1'b0;
    @(negedge clk);
    zero_chk("rst_pop");
    rst = 1'b0;
    p0 = npop;
    repeat (10) @(negedge clk);
    chk("rst_pop_nopop", npop - p0, 0);
    nvalid = 0;
    for (int i = 0; i < 4; i++) frame(4'd1, 1'b0);
    block_chk("post_rst", 4, 1);

    // clip counter saturation, then clear colliding with a clip
    for (int i = 0; i < 256; i++) frame(4'd7, 1'b0);
    chk("clip_sat", int'(clip_cnt), 255);
    frame(4'd7, 1'b1);
    chk("clip_clr_wins", int'(clip_cnt), 0);
    frame(4'h8, 1'b0);
    chk("clip_resume", int'(clip_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdm_rx_drain.md
Name: sdm_rx_drain

Overview:
- Sits directly downstream of the sigma-delta receiver in the same clock domain.
- Detects the receiver's `full` flag, waits for the receiver's decoded 4-bit signed sample to settle, captures it and pops the receiver.
- Decimates by accumulating 2^LOG2N captured samples, then emits the block sum and the floor average with a one-cycle valid strobe.
- Also counts clipped samples and flags handshake timeouts.

Parameters:
- LOG2N, 2, log2 of samples per output block (1..8).
- SETTLE, 3, cycles waited after `full` is seen high before `rdata` is captured (1..15); covers the receiver's 2-cycle decode delay.
- TMO, 64, cycles allowed for `full` to drop after `pop` before a timeout is declared (2..255).

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, synchronous reset, active high.
- enable, input, 1, run enable.
- full, input, 1, receiver holds a frame.
- rdata, input, 4, signed sample from receiver, two's complement, -8..+7.
- pop, output, 1, one-cycle pop strobe to receiver.
- sum_out, output, 4+LOG2N, signed block sum.
- avg_out, output, 4, signed block average, sum_out >>> LOG2N.
- out_valid, output, 1, one-cycle strobe; sum_out/avg_out updated this cycle.
- clip_cnt, output, 8, count of captured samples equal to -8 or +7; saturates at 255.
- err_timeout, output, 1, sticky handshake timeout flag.
- clr_err, input, 1, clears err_timeout and clip_cnt.

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (sampled on a clk rising edge with rst=1): pop=0, sum_out=0, avg_out=0, out_valid=0, clip_cnt=0, err_timeout=0; FSM=IDLE; accumulator=0, sample count=0, timers=0. Reset mid-handshake aborts immediately with no further pop.
- FSM states: IDLE, SETTLE, CAPTURE, POP, WAITLOW.
- IDLE: if enable=1 and full=1, go to SETTLE and load settle timer=SETTLE-1. If enable=0, clear accumulator and sample count.
- SETTLE: decrement the timer; at 0 go to CAPTURE.
- CAPTURE: latch rdata, sign-extend it and add to the accumulator. If the sample is -8 or +7, increment clip_cnt (saturating). Increment sample count. Go to POP.
- POP: pop=1 for exactly this cycle. Go to WAITLOW; timeout timer=0.
- WAITLOW: if full=0, go to IDLE. Otherwise increment the timer; at TMO set err_timeout=1, re-assert pop for one cycle, reset the timer and stay in WAITLOW.
- Latency: full seen high at edge t → capture at edge t+SETTLE+1 → pop high during cycle t+SETTLE+2.
- Block completion: when the CAPTURE cycle holds the 2^LOG2N-th sample, the next cycle has:
  - sum_out = accumulator including that sample;
  - avg_out = that sum arithmetically shifted right LOG2N (floor toward -inf);
  - out_valid=1 for one cycle;
  - accumulator and count cleared in the same edge.
- Widths: the accumulator is 4+LOG2N bits signed and cannot overflow: range -8·2^LOG2N .. 7·2^LOG2N.
- enable dropping mid-handshake: the current SETTLE/CAPTURE/POP/WAITLOW sequence completes; the partial block is discarded on return to IDLE. out_valid never fires for a partial block.
- full already low in the POP cycle: WAITLOW exits to IDLE on the next edge.
- clr_err in the same cycle as a new timeout or clip: the clear wins; the flag/count is 0 next cycle.
- clip_cnt holds at 255 once saturated.
- sum_out/avg_out hold their value between strobes.

Test Plan:
- LOG2N=2, SETTLE=3: four frames with rdata=+3 → pop one cycle per frame at t+5 after full; one out_valid with sum_out=12, avg_out=3, clip_cnt=0.
- Four frames of rdata=-8 → sum_out=-32, avg_out=-8, clip_cnt=4. Then pulse clr_err → clip_cnt=0.
- Frames +1, -2, 0, 0 → sum_out=-1, avg_out=-1 (floor); then frames +7, +7, +7, +6 → sum_out=27, avg_out=6, clip_cnt=3.
- Hold full high for 200 cycles after pop with TMO=64 → err_timeout=1 after 64 cycles; extra pops every 64 cycles; return to IDLE only when full drops.
- Deliver two samples, drop enable, deliver nothing, raise enable, then four samples of +2 → single out_valid with sum_out=8 (the first two samples are discarded).
- Assert rst during SETTLE and during POP → pop low and all outputs 0 on the next edge; the following frame is processed normally from IDLE.
